// File: rtl/hpu_reset_seq_pkg.sv
// Shared types and sizing helpers for the HPU root reset sequencer.
package hpu_reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ERROR  = 2'd3
  } seq_state_e;

  // Bits needed to hold the value max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hpu_reset_ack_pipe.sv
// Pipelined return path for the per-part reset-done flags; kept as its own hierarchy so
// it can carry the same SLR-crossing constraints as the forward reset chain.
module hpu_reset_ack_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/hpu_reset_seq.sv
// Root-side reset sequencer: holds the distribution-chain reset for a minimum time,
// gathers piped per-part done flags and services a four-phase soft-reset handshake.
module hpu_reset_seq
  import hpu_reset_seq_pkg::*;
#(
  parameter int unsigned PART_NB     = 3,
  parameter int unsigned ACK_PIPE    = 3,
  parameter int unsigned HOLD_CYCLES = 32,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               s_rst_n,
  input  logic               soft_rst_req,
  output logic               soft_rst_ack,
  output logic               part_rst_n,
  input  logic [PART_NB-1:0] part_done,
  output logic [PART_NB-1:0] done_vec,
  output logic               rst_busy,
  output logic               rst_ready,
  output logic               rst_timeout
);

  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int unsigned TMO_W  = cnt_w(TIMEOUT);

  seq_state_e          r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_soft_pend;
  logic                r_soft_ack;
  logic                r_part_rst_n;
  logic                r_busy;
  logic                r_ready;
  logic                r_timeout;
  logic [PART_NB-1:0]  w_done_vec;
  logic                w_all_done;
  logic                w_pipe_clr;

  assign w_pipe_clr = (r_state == ASSERT);
  assign w_all_done = &w_done_vec;

  hpu_reset_ack_pipe #(
    .WIDTH (PART_NB),
    .DEPTH (ACK_PIPE)
  ) u_ack_pipe (
    .i_clk   (clk),
    .i_rst_n (s_rst_n),
    .i_clr   (w_pipe_clr),
    .i_d     (part_done),
    .o_q     (w_done_vec)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state      <= ASSERT;
      r_hold_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_soft_pend  <= 1'b0;
      r_soft_ack   <= 1'b0;
      r_part_rst_n <= 1'b0;
      r_busy       <= 1'b1;
      r_ready      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        ASSERT: begin
          if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            r_state      <= WAIT;
            r_part_rst_n <= 1'b1;
            r_tmo_cnt    <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        WAIT: begin
          // All-done takes priority over the timeout limit in the same cycle.
          if (w_all_done) begin
            r_state     <= READY;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_soft_ack  <= r_soft_pend;
            r_soft_pend <= 1'b0;
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            r_state     <= ERROR;
            r_timeout   <= 1'b1;
            r_busy      <= 1'b0;
            r_soft_ack  <= r_soft_pend;
            r_soft_pend <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        READY, ERROR: begin
          if (soft_rst_req && !r_soft_ack) begin
            r_state      <= ASSERT;
            r_part_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_ready      <= 1'b0;
            r_timeout    <= 1'b0;
            r_hold_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_soft_pend  <= 1'b1;
          end else if (r_soft_ack && !soft_rst_req) begin
            r_soft_ack <= 1'b0;
          end
        end
        default: r_state <= ASSERT;
      endcase
    end
  end

  assign soft_rst_ack = r_soft_ack;
  assign part_rst_n   = r_part_rst_n;
  assign done_vec     = w_done_vec;
  assign rst_busy     = r_busy;
  assign rst_ready    = r_ready;
  assign rst_timeout  = r_timeout;

endmodule

// File: tb/tb_hpu_reset_seq.sv
// Directed bench for hpu_reset_seq: power-on, staggered done, soft handshake,
// async abort, timeout and the timeout/ready boundary.
module tb_hpu_reset_seq;

  logic       clk;
  logic       s_rst_n;
  logic       soft_rst_req;
  logic       soft_rst_ack;
  logic       part_rst_n;
  logic [2:0] part_done;
  logic [2:0] done_vec;
  logic       rst_busy;
  logic       rst_ready;
  logic       rst_timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  hpu_reset_seq #(
    .PART_NB     (3),
    .ACK_PIPE    (3),
    .HOLD_CYCLES (32),
    .TIMEOUT     (4096)
  ) dut (
    .clk          (clk),
    .s_rst_n      (s_rst_n),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .part_rst_n   (part_rst_n),
    .part_done    (part_done),
    .done_vec     (done_vec),
    .rst_busy     (rst_busy),
    .rst_ready    (rst_ready),
    .rst_timeout  (rst_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    s_rst_n      = 1'b0;
    soft_rst_req = 1'b0;
    part_done    = 3'b111;
    tick(2);
    chk("rst_part_rst_n", 32'(part_rst_n), 0);
    chk("rst_busy",       32'(rst_busy), 1);
    chk("rst_ready",      32'(rst_ready), 0);
    chk("rst_timeout",    32'(rst_timeout), 0);
    chk("rst_ack",        32'(soft_rst_ack), 0);
    chk("rst_done_vec",   32'(done_vec), 0);

    // Power-on: hold 32 cycles, ready at 32+3+1
    s_rst_n = 1'b1;
    tick(31);
    chk("po_hold_31", 32'(part_rst_n), 0);
    tick(1);
    chk("po_release_32", 32'(part_rst_n), 1);
    chk("po_busy_wait", 32'(rst_busy), 1);
    tick(3);
    chk("po_ready_35", 32'(rst_ready), 0);
    chk("po_done_vec_35", 32'(done_vec), 7);
    tick(1);
    chk("po_ready_36", 32'(rst_ready), 1);
    chk("po_busy_36", 32'(rst_busy), 0);
    chk("po_ack_none", 32'(soft_rst_ack), 0);

    // Soft reset with staggered part done
    part_done    = 3'b000;
    soft_rst_req = 1'b1;
    tick(1);
    chk("sr_accept_rst", 32'(part_rst_n), 0);
    chk("sr_accept_ready", 32'(rst_ready), 0);
    chk("sr_accept_busy", 32'(rst_busy), 1);
    tick(31);
    chk("sr_hold_31", 32'(part_rst_n), 0);
    tick(1);
    chk("sr_release_32", 32'(part_rst_n), 1);
    for (int c = 1; c <= 102; c++) begin
      part_done = {c >= 100, c >= 40, c >= 5};
      tick(1);
      if (c == 101) chk("stg_done_vec_101", 32'(done_vec), 3);
    end
    chk("stg_ready_102", 32'(rst_ready), 0);
    tick(1);
    chk("stg_ready_103", 32'(rst_ready), 1);
    chk("stg_ack_103", 32'(soft_rst_ack), 1);
    chk("stg_busy_103", 32'(rst_busy), 0);
    tick(5);
    chk("hold_req_ready", 32'(rst_ready), 1);
    chk("hold_req_no_reseq", 32'(part_rst_n), 1);
    chk("hold_req_ack", 32'(soft_rst_ack), 1);
    soft_rst_req = 1'b0;
    tick(1);
    chk("drop_req_ack", 32'(soft_rst_ack), 0);
    chk("drop_req_ready", 32'(rst_ready), 1);
    soft_rst_req = 1'b1;
    tick(1);
    chk("rereq_rst", 32'(part_rst_n), 0);
    chk("rereq_ready", 32'(rst_ready), 0);
    tick(35);
    chk("rereq_ready_35", 32'(rst_ready), 0);
    tick(1);
    chk("rereq_ready_36", 32'(rst_ready), 1);
    chk("rereq_ack", 32'(soft_rst_ack), 1);
    soft_rst_req = 1'b0;
    tick(1);
    chk("rereq_ack_drop", 32'(soft_rst_ack), 0);

    // Async reset in WAIT
    part_done    = 3'b000;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(32);
    chk("ab_in_wait", 32'(part_rst_n), 1);
    part_done = 3'b001;
    tick(10);
    chk("ab_wait_busy", 32'(rst_busy), 1);
    chk("ab_wait_done_vec", 32'(done_vec), 1);
    #2 s_rst_n = 1'b0;
    #1;
    chk("ab_async_rst_n", 32'(part_rst_n), 0);
    chk("ab_async_busy", 32'(rst_busy), 1);
    chk("ab_async_done_vec", 32'(done_vec), 0);
    tick(2);
    part_done    = 3'b111;
    soft_rst_req = 1'b1;
    s_rst_n      = 1'b1;
    tick(20);
    chk("ab_req_ignored", 32'(part_rst_n), 0);
    soft_rst_req = 1'b0;
    tick(11);
    chk("ab_hold_31", 32'(part_rst_n), 0);
    tick(1);
    chk("ab_release_32", 32'(part_rst_n), 1);
    tick(4);
    chk("ab_ready", 32'(rst_ready), 1);
    chk("ab_no_ack", 32'(soft_rst_ack), 0);

    // Timeout with part 1 stuck low
    part_done = 3'b101;
    s_rst_n   = 1'b0;
    tick(2);
    s_rst_n = 1'b1;
    tick(32);
    chk("to_in_wait", 32'(part_rst_n), 1);
    tick(4095);
    chk("to_not_yet", 32'(rst_timeout), 0);
    chk("to_busy_4095", 32'(rst_busy), 1);
    tick(1);
    chk("to_flag", 32'(rst_timeout), 1);
    chk("to_ready", 32'(rst_ready), 0);
    chk("to_busy", 32'(rst_busy), 0);
    chk("to_done_vec", 32'(done_vec), 5);
    tick(20);
    chk("to_sticky", 32'(rst_timeout), 1);
    part_done    = 3'b111;
    soft_rst_req = 1'b1;
    tick(1);
    chk("to_soft_clear", 32'(rst_timeout), 0);
    chk("to_soft_rst", 32'(part_rst_n), 0);
    chk("to_soft_busy", 32'(rst_busy), 1);
    tick(36);
    chk("to_soft_ready", 32'(rst_ready), 1);
    chk("to_soft_ack", 32'(soft_rst_ack), 1);
    tick(3);
    chk("to_ack_held", 32'(soft_rst_ack), 1);
    soft_rst_req = 1'b0;
    tick(1);
    chk("to_ack_drop", 32'(soft_rst_ack), 0);

    // Boundary: all done seen exactly at the timeout limit
    part_done    = 3'b000;
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk("bd_accept", 32'(part_rst_n), 0);
    tick(32);
    chk("bd_in_wait", 32'(part_rst_n), 1);
    for (int c = 1; c <= 4095; c++) begin
      part_done = (c >= 4093) ? 3'b111 : 3'b000;
      tick(1);
    end
    chk("bd_ready_4095", 32'(rst_ready), 0);
    chk("bd_timeout_4095", 32'(rst_timeout), 0);
    tick(1);
    chk("bd_ready_4096", 32'(rst_ready), 1);
    chk("bd_timeout_4096", 32'(rst_timeout), 0);
    chk("bd_ack", 32'(soft_rst_ack), 1);
    tick(1);
    chk("bd_ack_drop", 32'(soft_rst_ack), 0);

    // A done bit dropping in READY is ignored
    part_done = 3'b000;
    tick(10);
    chk("rdy_drop_ready", 32'(rst_ready), 1);
    chk("rdy_drop_busy", 32'(rst_busy), 0);
    chk("rdy_drop_rst", 32'(part_rst_n), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
